// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshake bundle for the shared memory port.
//   fetch_*  : fetch requester (req/addr in, done/rdata out)
//   data_*   : load/store requester (req/we/addr/wdata in, done/rdata out)
//   mem_*    : single-ported memory handshake (req/we/addr/wdata out, ready/rdata in)
//   bus_err  : sticky timeout flag
//   slave    : arbiter side; master : requester/memory environment side
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_done;
    logic [DATA_W-1:0] fetch_rdata;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_done;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              bus_err;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               mem_ready, mem_rdata,
        output fetch_done, fetch_rdata, data_done, data_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               mem_ready, mem_rdata,
        input  fetch_done, fetch_rdata, data_done, data_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with fairness and timeout.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requesters, memory handshake, bus_err)
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FAIR_LIMIT = 4,
    parameter int TIMEOUT    = 64
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        fair_q, fair_d;
    logic [7:0]        wait_q, wait_d;
    logic              err_q, err_d;
    logic              fdone_q, fdone_d;
    logic              ddone_q, ddone_d;
    logic              grant_f;

    // Data has priority unless it has already taken FAIR_LIMIT grants ahead of a waiting fetch.
    assign grant_f = bus.fetch_req && (!bus.data_req || fair_q == 4'(FAIR_LIMIT));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fair_d  = fair_q;
        wait_d  = wait_q;
        err_d   = err_q;
        fdone_d = 1'b0;
        ddone_d = 1'b0;
        case (state_q)
            IDLE: if (bus.fetch_req || bus.data_req) begin
                state_d = WAIT;
                owner_d = !grant_f;
                we_d    = !grant_f && bus.data_we;
                addr_d  = grant_f ? bus.fetch_addr : bus.data_addr;
                wdata_d = grant_f ? wdata_q : bus.data_wdata;
                wait_d  = '0;
                fair_d  = (grant_f || !bus.fetch_req) ? 4'd0 :
                          (fair_q == 4'(FAIR_LIMIT)) ? fair_q : fair_q + 4'd1;
            end
            WAIT: begin
                wait_d = wait_q + 8'd1;
                if (bus.mem_ready || wait_q == 8'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    err_d   = err_q || !bus.mem_ready;
                    fdone_d = !owner_q;
                    ddone_d = owner_q;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fair_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            fdone_q <= 1'b0;
            ddone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fair_q  <= fair_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            fdone_q <= fdone_d;
            ddone_q <= ddone_d;
        end
    end

    // mem_req decodes the state register, so an async reset drops it immediately.
    assign bus.mem_req     = state_q == WAIT;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.fetch_done  = fdone_q;
    assign bus.data_done   = ddone_q;
    assign bus.fetch_rdata = rdata_q;
    assign bus.data_rdata  = rdata_q;
    assign bus.bus_err     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        string order;
        logic  exp_d;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        #12;
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_dones", {bus.fetch_done, bus.data_done}, 0);
        chk("rst_bus_err", 32'(bus.bus_err), 0);
        chk("rst_rdata", bus.fetch_rdata, 0);
        rst_n = 1'b1;
        tick();

        // single zero-wait fetch
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h40;
        tick();
        chk("f_mem_req", 32'(bus.mem_req), 1);
        chk("f_mem_we", 32'(bus.mem_we), 0);
        chk("f_mem_addr", bus.mem_addr, 32'h40);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h00500093;
        tick();
        chk("f_done", 32'(bus.fetch_done), 1);
        chk("f_rdata", bus.fetch_rdata, 32'h00500093);
        chk("f_ddone", 32'(bus.data_done), 0);
        chk("f_resp_mem_req", 32'(bus.mem_req), 0);
        bus.fetch_req = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        chk("f_done_once", 32'(bus.fetch_done), 0);

        // store with 3 wait cycles, address changed mid-WAIT
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_addr  = 32'h100;
        bus.data_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) bus.data_addr = 32'h200;
            chk("s_mem_req", 32'(bus.mem_req), 1);
            chk("s_mem_we", 32'(bus.mem_we), 1);
            chk("s_mem_addr", bus.mem_addr, 32'h100);
            chk("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
            chk("s_no_done", 32'(bus.data_done), 0);
        end
        bus.mem_ready = 1'b1;
        tick();
        chk("s_done", 32'(bus.data_done), 1);
        chk("s_fdone", 32'(bus.fetch_done), 0);
        bus.data_req = 1'b0;
        tick();
        chk("s_done_once", 32'(bus.data_done), 0);
        tick();
        chk("idle_ready_no_done", {bus.fetch_done, bus.data_done}, 0);
        chk("idle_mem_req", 32'(bus.mem_req), 0);
        bus.mem_ready = 1'b0;

        // both held: fairness order
        order = "DDDDFDDDDF";
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h80;
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_addr  = 32'h300;
        for (int i = 0; i < 10; i++) begin
            exp_d = order[i] == "D";
            tick();
            chk("fair_addr", bus.mem_addr, exp_d ? 32'h300 : 32'h80);
            bus.mem_ready = 1'b1;
            tick();
            chk("fair_done", {bus.fetch_done, bus.data_done}, exp_d ? 32'd1 : 32'd2);
            bus.mem_ready = 1'b0;
            tick();
        end
        bus.fetch_req = 1'b0;
        bus.data_req  = 1'b0;
        tick();

        // timeout on a fetch
        bus.fetch_req = 1'b1;
        bus.fetch_addr = 32'h44;
        tick();
        chk("to_err_before", 32'(bus.bus_err), 0);
        for (int i = 1; i < 64; i++) begin
            tick();
            if (bus.fetch_done) chk("to_early_done", 32'(i), 64);
        end
        chk("to_still_waiting", 32'(bus.mem_req), 1);
        tick();
        chk("to_done", 32'(bus.fetch_done), 1);
        chk("to_rdata", bus.fetch_rdata, 0);
        chk("to_bus_err", 32'(bus.bus_err), 1);
        bus.fetch_req = 1'b0;
        tick();

        // successful load afterwards: bus_err stays
        bus.data_req  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_addr = 32'h104;
        tick();
        chk("ld_mem_we", 32'(bus.mem_we), 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h00001234;
        tick();
        chk("ld_done", 32'(bus.data_done), 1);
        chk("ld_rdata", bus.data_rdata, 32'h00001234);
        chk("ld_bus_err_sticky", 32'(bus.bus_err), 1);
        bus.data_req  = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // reset during WAIT
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h48;
        tick();
        chk("rw_mem_req", 32'(bus.mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_async_drop", 32'(bus.mem_req), 0);
        bus.fetch_req = 1'b0;
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk("rw_no_done", {bus.fetch_done, bus.data_done}, 0);
        chk("rw_idle", 32'(bus.mem_req), 0);
        chk("rw_err_clr", 32'(bus.bus_err), 0);
        chk("rw_addr_clr", bus.mem_addr, 0);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h4C;
        tick();
        chk("rw_regrant", bus.mem_addr, 32'h4C);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        tick();
        chk("rw_done", 32'(bus.fetch_done), 1);
        chk("rw_rdata", bus.fetch_rdata, 32'hCAFEF00D);
        bus.fetch_req = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
